// File: rtl/param_flag_divider_pkg.sv
// Shared constants for the parametrised flag divider.
package param_flag_divider_pkg;

  localparam int DEF_CNT_W = 8;
  localparam int MIN_DIV   = 2;
  localparam int DEF_DIV   = 5;

endpackage

// File: rtl/param_flag_divider_cfg_shadow.sv
// Ratio shadow: validates requested ratios, holds the pending one and swaps
// it into the active ratio only on a period wrap.
module param_flag_divider_cfg_shadow
  import param_flag_divider_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DEFAULT_DIV = DEF_DIV
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             cfg_load,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             apply,
  output logic [CNT_W-1:0] div_act,
  output logic [CNT_W-1:0] div_nxt,
  output logic             cfg_err
);

  logic [CNT_W-1:0] pend_div;
  logic             pend_vld;
  logic             cfg_ok;

  assign cfg_ok = (cfg_div >= CNT_W'(MIN_DIV));

  // Ratio the counter core will run with after this edge.
  always_comb begin
    div_nxt = div_act;
    if (apply && pend_vld) div_nxt = pend_div;
  end

  // Pending/active ratio registers. A load coinciding with a wrap is
  // written after the apply, so it survives for the following wrap.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      div_act  <= CNT_W'(DEFAULT_DIV);
      pend_div <= CNT_W'(DEFAULT_DIV);
      pend_vld <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      div_act <= div_nxt;
      cfg_err <= cfg_load && !cfg_ok;
      if (apply && pend_vld) pend_vld <= 1'b0;
      if (cfg_load && cfg_ok) begin
        pend_div <= cfg_div;
        pend_vld <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/param_flag_divider.sv
// Runtime-programmable clock-enable divider: one-cycle flag per period,
// near-50% square wave and phase count, all in the sys_clk domain.
module param_flag_divider
  import param_flag_divider_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DEFAULT_DIV = DEF_DIV
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             en,
  input  logic             cfg_load,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_err,
  output logic             clk_flag,
  output logic             clk_out,
  output logic [CNT_W-1:0] cnt_out
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] div_act;
  logic [CNT_W-1:0] div_nxt;
  logic             wrap;
  logic             last_q;
  logic             clk_out_q;

  assign wrap = en && (cnt == (div_act - CNT_W'(1)));

  param_flag_divider_cfg_shadow #(
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_cfg_shadow (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .cfg_load (cfg_load),
    .cfg_div  (cfg_div),
    .apply    (wrap),
    .div_act  (div_act),
    .div_nxt  (div_nxt),
    .cfg_err  (cfg_err)
  );

  // Next phase count: advance when enabled, wrap at the last phase.
  always_comb begin
    cnt_nxt = cnt;
    if (en) cnt_nxt = wrap ? '0 : cnt + CNT_W'(1);
  end

  // Count and decoded outputs are registered from next-state values so they
  // line up with cnt_out in the same cycle without a path from cnt.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt       <= '0;
      last_q    <= 1'b0;
      clk_out_q <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      last_q    <= (cnt_nxt == (div_nxt - CNT_W'(1)));
      clk_out_q <= (cnt_nxt >= (div_nxt >> 1));
    end
  end

  // The flag is qualified by en so a stalled last cycle produces no pulse;
  // the pulse then lands on the first enabled cycle, where the wrap happens.
  assign clk_flag = last_q && en;
  assign clk_out  = clk_out_q;
  assign cnt_out  = cnt;

endmodule

// File: tb/tb_param_flag_divider.sv
// Directed bench for param_flag_divider with hand-computed expectations.
module tb_param_flag_divider;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       en = 1'b0;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_div = '0;
  logic       cfg_err;
  logic       clk_flag;
  logic       clk_out;
  logic [7:0] cnt_out;

  int n_chk = 0;
  int n_err = 0;

  param_flag_divider dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .en       (en),
    .cfg_load (cfg_load),
    .cfg_div  (cfg_div),
    .cfg_err  (cfg_err),
    .clk_flag (clk_flag),
    .clk_out  (clk_out),
    .cnt_out  (cnt_out)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then check that cycle's outputs.
  task automatic cyc(input logic e, input logic ld, input int dv,
                     input int ecnt, input int eflag, input int eout, input int eerr);
    @(negedge sys_clk);
    sys_rst  = 1'b0;
    en       = e;
    cfg_load = ld;
    cfg_div  = 8'(dv);
    #1;
    chk("cnt_out", int'(cnt_out), ecnt);
    chk("clk_flag", int'(clk_flag), eflag);
    chk("clk_out", int'(clk_out), eout);
    chk("cfg_err", int'(cfg_err), eerr);
  endtask

  // One full enabled period of ratio n starting at cnt 0.
  task automatic run_period(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b1, 1'b0, 0, i, (i == n - 1) ? 1 : 0, (i >= n / 2) ? 1 : 0, 0);
  endtask

  // Reset for one edge while other inputs try to disturb the state.
  task automatic reset_pulse();
    @(negedge sys_clk);
    sys_rst  = 1'b1;
    en       = 1'b1;
    cfg_load = 1'b1;
    cfg_div  = 8'd9;
  endtask

  int flags;

  initial begin
    reset_pulse();
    // Reset state, en low.
    cyc(1'b0, 1'b0, 0, 0, 0, 0, 0);

    // Default N=5 for 15 cycles (counter still at 0).
    flags = 0;
    for (int i = 0; i < 15; i++) begin
      cyc(1'b1, 1'b0, 0, i % 5, (i % 5 == 4) ? 1 : 0, (i % 5 >= 2) ? 1 : 0, 0);
      if (clk_flag) flags++;
    end
    chk("flag_count", flags, 3);

    // Load 3 at cnt 1: current period stays 5 long, then N=3.
    cyc(1'b1, 1'b0, 0, 0, 0, 0, 0);
    cyc(1'b1, 1'b1, 3, 1, 0, 0, 0);
    cyc(1'b1, 1'b0, 0, 2, 0, 1, 0);
    cyc(1'b1, 1'b0, 0, 3, 0, 1, 0);
    cyc(1'b1, 1'b0, 0, 4, 1, 1, 0);
    run_period(3);
    run_period(3);

    // 7 then 4 back to back: last wins, no 7-long period.
    cyc(1'b1, 1'b1, 7, 0, 0, 0, 0);
    cyc(1'b1, 1'b1, 4, 1, 0, 1, 0);
    cyc(1'b1, 1'b0, 0, 2, 1, 1, 0);
    run_period(4);
    run_period(4);

    // Load 5 on the wrap cycle: not applied there, applied one wrap later.
    cyc(1'b1, 1'b0, 0, 0, 0, 0, 0);
    cyc(1'b1, 1'b0, 0, 1, 0, 0, 0);
    cyc(1'b1, 1'b0, 0, 2, 0, 1, 0);
    cyc(1'b1, 1'b1, 5, 3, 1, 1, 0);
    run_period(4);
    run_period(5);

    // Invalid ratios 1 and 0: cfg_err one cycle later each, ratio stays 5.
    cyc(1'b1, 1'b1, 1, 0, 0, 0, 0);
    cyc(1'b1, 1'b1, 0, 1, 0, 0, 1);
    cyc(1'b1, 1'b0, 0, 2, 0, 1, 1);
    cyc(1'b1, 1'b0, 0, 3, 0, 1, 0);
    cyc(1'b1, 1'b0, 0, 4, 1, 1, 0);
    run_period(5);

    // en low for 3 cycles at cnt 4: frozen, no flag; flag on resume.
    cyc(1'b1, 1'b0, 0, 0, 0, 0, 0);
    cyc(1'b1, 1'b0, 0, 1, 0, 0, 0);
    cyc(1'b1, 1'b0, 0, 2, 0, 1, 0);
    cyc(1'b1, 1'b0, 0, 3, 0, 1, 0);
    cyc(1'b0, 1'b0, 0, 4, 0, 1, 0);
    cyc(1'b0, 1'b0, 0, 4, 0, 1, 0);
    cyc(1'b0, 1'b0, 0, 4, 0, 1, 0);
    cyc(1'b1, 1'b0, 0, 4, 1, 1, 0);
    run_period(5);

    // Reset at cnt 2 with ratio 8 pending: pending discarded, N=5 resumes.
    cyc(1'b1, 1'b1, 8, 0, 0, 0, 0);
    cyc(1'b1, 1'b0, 0, 1, 0, 0, 0);
    reset_pulse();
    cyc(1'b1, 1'b0, 0, 0, 0, 0, 0);
    cyc(1'b1, 1'b0, 0, 1, 0, 0, 0);
    cyc(1'b1, 1'b0, 0, 2, 0, 1, 0);
    cyc(1'b1, 1'b0, 0, 3, 0, 1, 0);
    cyc(1'b1, 1'b0, 0, 4, 1, 1, 0);
    run_period(5);

    // Minimum ratio N=2.
    cyc(1'b1, 1'b1, 2, 0, 0, 0, 0);
    cyc(1'b1, 1'b0, 0, 1, 0, 0, 0);
    cyc(1'b1, 1'b0, 0, 2, 0, 1, 0);
    cyc(1'b1, 1'b0, 0, 3, 0, 1, 0);
    cyc(1'b1, 1'b0, 0, 4, 1, 1, 0);
    run_period(2);
    run_period(2);

    // Maximum ratio N=255, then wraps cleanly back to 0.
    cyc(1'b1, 1'b1, 255, 0, 0, 0, 0);
    cyc(1'b1, 1'b0, 0, 1, 1, 1, 0);
    run_period(255);
    cyc(1'b1, 1'b0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/param_flag_divider.md
Name: param_flag_divider

Overview:
- Parametrised integer clock-enable divider; generalises the fixed divide-by-5 flag generator.
- Runtime-programmable ratio N (2..2^CNT_W-1), applied glitch-free at period boundaries.
- Produces a one-cycle flag per period, a near-50% square wave, and the phase count.
- Feeds clock-enable inputs of downstream blocks in the same sys_clk domain; no derived clocks are created.

Parameters:
- CNT_W, 8, counter and ratio width in bits.
- DEFAULT_DIV, 5, ratio active after reset; must be 2..2^CNT_W-1.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- en  in  1  count enable; low freezes the divider.
- cfg_load  in  1  one-cycle strobe; requests the new ratio on cfg_div.
- cfg_div  in  CNT_W  requested ratio N, sampled when cfg_load=1.
- cfg_err  out  1  one-cycle pulse: rejected cfg_div (<2).
- clk_flag  out  1  high exactly during the last cycle of each period.
- clk_out  out  1  square wave: low floor(N/2) cycles, then high ceil(N/2) cycles.
- cnt_out  out  CNT_W  current phase count 0..N-1.

Behaviour:
- Reset (sys_rst=1 at an edge): cnt=0, div_act=DEFAULT_DIV, pending flag cleared, clk_flag=0, clk_out=0, cfg_err=0. sys_rst overrides all other inputs.
- Counting: when en=1, cnt increments each cycle; when cnt==div_act-1 it wraps to 0. When en=0, cnt, div_act, clk_out and cnt_out hold; clk_flag=0.
- Outputs are registered and exactly consistent with cnt_out in the same cycle:
  - clk_flag = (cnt==div_act-1) && en. It is produced from the previous-cycle comparison, so there is no combinational path from cnt.
  - clk_out = (cnt >= div_act/2), using integer division. N=5 gives 0,0,1,1,1. N=4 gives 0,0,1,1.
- Ratio update:
  - cfg_load with cfg_div>=2: the value is stored in a pending register and the pending flag is set. A later cfg_load before application overwrites it (last wins).
  - cfg_load with cfg_div<2: cfg_err=1 for one cycle next edge; pending register and flag are unchanged.
  - Application: on the wrap edge (en=1, cnt==div_act-1), if pending is set, div_act <= pending and the pending flag is cleared. The new period starts at cnt=0 under the new N.
  - A cfg_load in the same cycle as a wrap is not applied at that wrap; it takes effect at the following wrap.
  - A ratio change never shortens or stretches the current period.
- en deasserted during the last cycle of a period (cnt==N-1): clk_flag=0 that cycle. The wrap and flag occur on the first enabled cycle thereafter, so exactly one flag per period is preserved.
- N=2: clk_flag toggles 0,1; clk_out 0,1.
- N=2^CNT_W-1: cnt reaches the all-ones-minus-one value and wraps; no overflow.
- Reset mid-period: immediate return to reset state; the pending request is discarded.
- Latency: cfg_err is one cycle after cfg_load. A ratio change takes effect 1..N cycles later, at the next wrap.

Decomposition:
- Shared package: CNT_W default, MIN_DIV=2, DEFAULT_DIV=5.
- Sub-module div_cfg_shadow: pending register, pending flag, validation and cfg_err generation. It hands div_act to the counter core.
- The counter and output logic stay in the top level.

Test Plan:
- Reset then en=1, default N=5 for 15 cycles -> cnt_out 0..4 repeating; clk_flag high at cnt 4 only (3 pulses); clk_out 0,0,1,1,1.
- At cnt=1, cfg_load with cfg_div=3 -> current period completes at 5 cycles; then cnt 0,1,2 with flag at 2 and clk_out 0,1,1.
- cfg_div=7 then cfg_div=4 in consecutive cycles before a wrap -> N=4 applied; no period of 7 ever occurs.
- cfg_load with cfg_div=1, and with cfg_div=0 -> cfg_err pulses one cycle after each; ratio stays 5; no flag disruption.
- en low for 3 cycles at cnt=4 -> outputs frozen with clk_flag=0; flag fires on the first enabled cycle; next flag 5 enabled cycles later.
- sys_rst=1 at cnt=2 with a pending ratio 8 -> all outputs 0 next edge; the following period uses N=5.
